// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier
// Description : Iterative shift-and-add unsigned multiplier, slowClk domain.
//               One operand pair is accepted per start request, and one
//               multiplier bit is retired per cycle. The product is held
//               stable and announced by a one-cycle done pulse so that the
//               downstream result register can capture it directly.
//
// Ports       : slowClk      - block clock, all state updates on posedge
//               reset        - synchronous, active-high reset
//               start        - multiplication request (sampled when idle)
//               multiplicand - unsigned operand A (OPERAND_WIDTH bits)
//               multiplier   - unsigned operand B (OPERAND_WIDTH bits)
//               busy         - high while iterating (RUN state)
//               done         - one-cycle pulse, product just updated
//               product      - A*B (PRODUCT_WIDTH bits), held until next result
//
// Options     : SHIFT_ADD_MULT_EARLY_TERM_EN - when defined, RUN ends as soon
//               as no set multiplier bits remain (minimum one iteration).
//
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier #(
  parameter int OPERAND_WIDTH = 2,
  parameter int PRODUCT_WIDTH = 2 * OPERAND_WIDTH
) (
  input  logic                     slowClk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [OPERAND_WIDTH-1:0] multiplicand,
  input  logic [OPERAND_WIDTH-1:0] multiplier,
  output logic                     busy,
  output logic                     done,
  output logic [PRODUCT_WIDTH-1:0] product
);

  localparam int CNT_WIDTH = (OPERAND_WIDTH > 1) ? $clog2(OPERAND_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] C_LAST_CNT = CNT_WIDTH'(OPERAND_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;

  logic [PRODUCT_WIDTH-1:0] r_mcand;
  logic [PRODUCT_WIDTH-1:0] r_acc;
  logic [PRODUCT_WIDTH-1:0] r_product;
  logic [OPERAND_WIDTH-1:0] r_mplier;
  logic [CNT_WIDTH-1:0]     r_cnt;
  logic                     r_done;

  logic [PRODUCT_WIDTH-1:0] w_addend;
  logic [PRODUCT_WIDTH-1:0] w_sum;
  logic                     w_last;
  logic                     w_accept;

  // Partial product for the current multiplier bit and the running sum.
  // The accumulator is wide enough for the full product, so it never wraps.
  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_sum    = r_acc + w_addend;

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
  // Stop as soon as the bits still to be shifted in are all zero: further
  // iterations would only add zero.
  assign w_last = (r_cnt == C_LAST_CNT) || ((r_mplier >> 1) == '0);
`else
  assign w_last = (r_cnt == C_LAST_CNT);
`endif

  // The edge that leaves DONE samples start just as IDLE would, so a request
  // held high is taken on that edge and back-to-back operations complete
  // every OPERAND_WIDTH+1 cycles. Requests seen during RUN are dropped.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // State register
  always_ff @(posedge slowClk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge slowClk) begin
    if (reset) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_mcand  <= {{(PRODUCT_WIDTH - OPERAND_WIDTH){1'b0}}, multiplicand};
        r_mplier <= multiplier;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (r_state == S_RUN) begin
        r_acc    <= w_sum;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (w_last) begin
          // Take the sum directly so the product appears with the final add.
          r_product <= w_sum;
          r_done    <= 1'b1;
        end
      end
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = r_done;
  assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_multiplier
// Description : Self-checking bench for shift_add_multiplier. Two instances
//               are exercised: OPERAND_WIDTH=2 (default) and OPERAND_WIDTH=4.
//               Drivers push the expected product and completion cycle into
//               a per-instance queue; monitors pop and compare on done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier;

  typedef struct {
    int prod;
    int cyc;
  } exp_t;

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
  localparam int L_B0 = 1;
  localparam int L_B1 = 1;
  localparam int L_B4 = 3;
`else
  localparam int L_B0 = 4;
  localparam int L_B1 = 4;
  localparam int L_B4 = 4;
`endif

  logic       slowClk;
  logic       reset;
  logic       start2, start4;
  logic [1:0] a2, b2;
  logic [3:0] a4, b4;
  logic       busy2, done2, busy4, done4;
  logic [3:0] p2;
  logic [7:0] p4;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic rst_edge = 1'b1;
  exp_t q2[$];
  exp_t q4[$];
  exp_t e2, e4;
  logic prev_done2 = 1'b0, prev_done4 = 1'b0;
  logic [3:0] prev_p2 = '0;
  logic [7:0] prev_p4 = '0;

  shift_add_multiplier #(.OPERAND_WIDTH(2)) u_dut2 (
    .slowClk      (slowClk),
    .reset        (reset),
    .start        (start2),
    .multiplicand (a2),
    .multiplier   (b2),
    .busy         (busy2),
    .done         (done2),
    .product      (p2)
  );

  shift_add_multiplier #(.OPERAND_WIDTH(4)) u_dut4 (
    .slowClk      (slowClk),
    .reset        (reset),
    .start        (start4),
    .multiplicand (a4),
    .multiplier   (b4),
    .busy         (busy4),
    .done         (done4),
    .product      (p4)
  );

  initial slowClk = 1'b0;
  always #5 slowClk = ~slowClk;

  // Edge counter: at a negedge, cyc equals the number of the edge just taken.
  always @(posedge slowClk) begin
    cyc      <= cyc + 1;
    rst_edge <= reset;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected RUN length for multiplier value b at width w.
  function automatic int lat(input logic [31:0] b, input int w);
    int l;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < w; i++) if (b[i]) l = i + 1;
`else
    l = w;
`endif
    return l;
  endfunction

  // ---------------------------------------------------------------- monitors
  always @(negedge slowClk) begin
    if (done2) begin
      if (q2.size() == 0) check("dut2 unexpected done", 1, 0);
      else begin
        e2 = q2.pop_front();
        check("dut2 product", 32'(p2), e2.prod);
        check("dut2 done cycle", cyc, e2.cyc);
      end
      check("dut2 done twice", 32'(prev_done2), 0);
    end
    if (!done2 && !rst_edge) check("dut2 product hold", 32'(p2), 32'(prev_p2));
    prev_done2 = done2;
    prev_p2    = p2;
  end

  always @(negedge slowClk) begin
    if (done4) begin
      if (q4.size() == 0) check("dut4 unexpected done", 1, 0);
      else begin
        e4 = q4.pop_front();
        check("dut4 product", 32'(p4), e4.prod);
        check("dut4 done cycle", cyc, e4.cyc);
      end
      check("dut4 done twice", 32'(prev_done4), 0);
    end
    if (!done4 && !rst_edge) check("dut4 product hold", 32'(p4), 32'(prev_p4));
    prev_done4 = done4;
    prev_p4    = p4;
  end

  // ----------------------------------------------------------------- drivers
  // Called at a negedge; start is accepted on the following edge k. Operands
  // are scrambled during RUN to show they were captured. Returns at the
  // negedge after edge k+L with start still high.
  task automatic issue2(input logic [1:0] a, input logic [1:0] b, input int exp_prod, input int exp_lat);
    int k;
    a2 = a; b2 = b; start2 = 1'b1;
    @(negedge slowClk);
    k = cyc;
    q2.push_back('{exp_prod, k + exp_lat});
    for (int i = 0; i < exp_lat; i++) begin
      check("dut2 busy in run", 32'(busy2), 1);
      a2 = ~a; b2 = ~b;
      @(negedge slowClk);
    end
    check("dut2 busy after run", 32'(busy2), 0);
  endtask

  // noisy=1: toggle start and drive 15/15 during RUN; those must be ignored.
  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input int exp_prod,
                        input int exp_lat, input bit noisy);
    int k;
    a4 = a; b4 = b; start4 = 1'b1;
    @(negedge slowClk);
    k = cyc;
    q4.push_back('{exp_prod, k + exp_lat});
    for (int i = 0; i < exp_lat; i++) begin
      check("dut4 busy in run", 32'(busy4), 1);
      if (noisy) begin
        start4 = (i % 2 == 0);
        a4 = 4'hF; b4 = 4'hF;
      end else begin
        a4 = ~a; b4 = ~b;
      end
      @(negedge slowClk);
    end
    check("dut4 busy after run", 32'(busy4), 0);
  endtask

  initial begin
    // Reset held with start active: everything must stay cleared.
    reset = 1'b1;
    start2 = 1'b1; a2 = 2'd3; b2 = 2'd3;
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge slowClk);
      check("reset busy2", 32'(busy2), 0);
      check("reset done2", 32'(done2), 0);
      check("reset product2", 32'(p2), 0);
      check("reset busy4", 32'(busy4), 0);
      check("reset done4", 32'(done4), 0);
      check("reset product4", 32'(p4), 0);
    end
    reset = 1'b0; start2 = 1'b0; start4 = 1'b0;
    @(negedge slowClk);
    check("idle after reset busy4", 32'(busy4), 0);

    // W=2 directed
    issue2(2'd3, 2'd2, 6, 2);
    start2 = 1'b0;
    @(negedge slowClk);
    issue2(2'd3, 2'd3, 9, 2);
    start2 = 1'b0;

    // W=4 exhaustive, start held high back to back
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        issue4(4'(a), 4'(b), a * b, lat(32'(b), 4), 1'b0);
    start4 = 1'b0;
    @(negedge slowClk);

    // Requests during RUN ignored; next accept on the edge leaving DONE.
    issue4(4'd5, 4'd7, 35, lat(32'd7, 4), 1'b1);
    issue4(4'd15, 4'd15, 225, lat(32'd15, 4), 1'b0);
    start4 = 1'b0;
    @(negedge slowClk);

    // Reset mid-RUN abandons the operation.
    a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
    @(negedge slowClk);
    start4 = 1'b0;
    @(negedge slowClk);
    reset = 1'b1;
    @(negedge slowClk);
    check("midrun reset busy4", 32'(busy4), 0);
    check("midrun reset done4", 32'(done4), 0);
    check("midrun reset product4", 32'(p4), 0);
    reset = 1'b0;
    @(negedge slowClk);
    issue4(4'd2, 4'd3, 6, lat(32'd3, 4), 1'b0);
    start4 = 1'b0;
    @(negedge slowClk);

    // Early-termination boundary vectors (fixed length when disabled).
    issue4(4'd7, 4'd0, 0, L_B0, 1'b0);
    start4 = 1'b0;
    @(negedge slowClk);
    issue4(4'd9, 4'd1, 9, L_B1, 1'b0);
    start4 = 1'b0;
    @(negedge slowClk);
    issue4(4'd3, 4'd4, 12, L_B4, 1'b0);
    start4 = 1'b0;

    // Let monitors drain outstanding expectations, bounded.
    repeat (3) @(negedge slowClk);
    for (int i = 0; i < 20 && (q2.size() + q4.size()) != 0; i++) @(negedge slowClk);
    check("scoreboard drained", 32'(q2.size() + q4.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
